bpu_sram_ctrl: RTL

Sequencing controller for one 256×24 predictor-table SRAM macro. The macro has one read port, one write port and four 6-bit write lanes. After reset and on every flush, the controller clears the whole table with a hardware sweep. It then serves lookup reads and buffers masked training writes in a 2-entry queue, draining one write per cycle into the macro. It sits between the BPU predictor stage / update logic and the SRAM instance.

---
 rtl/bpu_sram_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bpu_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bpu_sram_ctrl
// Purpose : Clear sweep, read pass-through and masked write queue for a
//           256x24 predictor-table SRAM macro.
// Rev     : 1.0  initial release
// ============================================================================
module bpu_sram_ctrl #(
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int DW     = 24,
    parameter int LANES  = 4,
    parameter int QDEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flush,
    output logic             io_init_done,
    input  logic             io_r_req_valid,
    output logic             io_r_req_ready,
    input  logic [AW-1:0]    io_r_req_addr,
    output logic             io_r_resp_valid,
    output logic [DW-1:0]    io_r_resp_data,
    input  logic             io_w_req_valid,
    output logic             io_w_req_ready,
    input  logic [AW-1:0]    io_w_req_addr,
    input  logic [DW-1:0]    io_w_req_data,
    input  logic [LANES-1:0] io_w_req_mask,
    output logic             sram_w_en,
    output logic [AW-1:0]    sram_w_addr,
    output logic [DW-1:0]    sram_w_data,
    output logic [LANES-1:0] sram_w_mask,
    output logic             sram_r_en,
    output logic [AW-1:0]    sram_r_addr,
    input  logic [DW-1:0]    sram_r_data
);

    localparam int c_PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CW = $clog2(QDEPTH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;

    localparam logic [AW-1:0]   c_LAST_ROW = AW'(DEPTH - 1);
    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(QDEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(QDEPTH);

    logic [1:0]       r_state;
    logic [AW-1:0]    r_clr_idx;
    logic             r_resp_valid;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic [AW-1:0]    r_q_addr [QDEPTH];
    logic [DW-1:0]    r_q_data [QDEPTH];
    logic [LANES-1:0] r_q_mask [QDEPTH];

    logic             w_run;
    logic             w_r_fire;
    logic             w_enq;
    logic             w_deq;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;

    assign w_run    = (r_state == c_RUN);
    assign w_r_fire = io_r_req_valid && w_run;

    // Ready looks at the pre-dequeue count, so a full queue never accepts
    // in the same cycle it drains.
    assign io_w_req_ready = (r_count < c_FULL) && !io_flush;
    assign w_enq          = io_w_req_valid && io_w_req_ready;
    assign w_deq          = w_run && (r_count != '0);

    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    assign io_init_done    = w_run;
    assign io_r_req_ready  = w_run;
    assign sram_r_en       = w_r_fire;
    assign sram_r_addr     = io_r_req_addr;
    assign io_r_resp_valid = r_resp_valid;
    assign io_r_resp_data  = sram_r_data;

    always_comb begin
        sram_w_en   = 1'b0;
        sram_w_addr = '0;
        sram_w_data = '0;
        sram_w_mask = '0;
        if (r_state == c_CLEAR) begin
            sram_w_en   = 1'b1;
            sram_w_addr = r_clr_idx;
            sram_w_mask = '1;
        end else if (w_deq) begin
            // An all-zero mask is still dequeued, just without touching the macro.
            sram_w_en   = |r_q_mask[r_rd_ptr];
            sram_w_addr = r_q_addr[r_rd_ptr];
            sram_w_data = r_q_data[r_rd_ptr];
            sram_w_mask = r_q_mask[r_rd_ptr];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_clr_idx    <= '0;
            r_resp_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_resp_valid <= w_r_fire;
            if (io_flush) begin
                r_state   <= c_CLEAR;
                r_clr_idx <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: r_state <= c_CLEAR;
                    c_CLEAR: begin
                        if (r_clr_idx == c_LAST_ROW) begin
                            r_state   <= c_RUN;
                            r_clr_idx <= '0;
                        end else begin
                            r_clr_idx <= r_clr_idx + 1'b1;
                        end
                    end
                    c_RUN:   r_state <= c_RUN;
                    default: r_state <= c_IDLE;
                endcase

                if (w_enq) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end
                if (w_deq) begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_q_addr[r_wr_ptr] <= io_w_req_addr;
            r_q_data[r_wr_ptr] <= io_w_req_data;
            r_q_mask[r_wr_ptr] <= io_w_req_mask;
        end
    end

endmodule
`default_nettype wire
